uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
// - UART serial receiver: oversamples RX_IN at PRESCALE clocks/bit and deframes start, W data bits (LSB first), optional parity and one stop bit.
// - On an error-free frame, presents the data word on P_DATA with a 1-cycle DATA_VALID strobe.
// - Sits at the serial-input edge of the UART block, feeding the receive data path.
// PARAMETERS
// - W  default 8  data bits per frame (width of P_DATA)
// PORTS
// - CLK         in   1   oversampling clock; all logic on rising edge
// - RST         in   1   asynchronous, active-high reset
// - PRESCALE    in   6   clocks per bit; legal 8..63, values <8 treated as 8
// - PER_EN      in   1   1 = parity bit present in frame
// - PAR_TYP     in   1   0 = even, 1 = odd parity
// - RX_IN       in   1   serial line, idle high
// - DATA_VALID  out  1   1-cycle strobe, frame received without error
// - P_DATA      out  W   last good data word
// BEHAVIOUR
// - Reset: FSM=IDLE, counters 0, DATA_VALID=0, P_DATA=0; asserting RST mid-frame aborts the frame with no strobe.
// - RX_IN passes through a 2-flop synchronizer (reset value 1); all timing below refers to the synchronized line.
// - PRESCALE/PER_EN/PAR_TYP are latched on start detection and held for the whole frame.
// - Per bit: edge counter 0..PRESCALE-1 and a bit counter.
//   - The line is sampled at counts P/2-1, P/2, P/2+1 (P = PRESCALE).
//   - Bit value = 2-of-3 majority, resolved at count P/2+1.
// - FSM states and transitions:
//   - IDLE: stay while line=1; a 1->0 transition -> START, edge counter=0.
//   - START: majority=0 -> DATA at bit end; majority=1 (glitch) -> IDLE immediately.
//   - DATA: shift W bits LSB first into the shift register; after bit W-1 -> PARITY if PER_EN, else STOP.
//   - PARITY: even error if bit != ^data; odd error if bit != ~^data. Always -> STOP at bit end.
//   - STOP: at majority resolve, stop=1 and no parity error -> P_DATA <= shift register, DATA_VALID=1 for exactly one cycle.
//     Then -> IDLE immediately (mid stop bit), so a start edge after the stop bit is caught: back-to-back frames are supported.
// - Stop=0 (framing error) or parity error: no strobe, P_DATA keeps its previous value.
// - P_DATA changes only on a good frame and is held until the next one.
// - The strobe lands inside the stop bit, so P_DATA is stable before the stop bit ends.
// - Line held low after a framing error: IDLE waits for line=1 and then a fresh 1->0 edge.
// CONFIGURATION
// - UART_RX_ERR_FLAGS_EN defined: adds outputs PAR_ERR and STP_ERR.
//   - Each is a 1-cycle pulse in the cycle a good frame would have strobed; reset value 0.
//   - STP_ERR has priority in reporting only: both assert if both errors occur.
// - Undefined: these ports and their logic are absent; error frames are silently dropped.
// STRUCTURE
// - Package uart_rx_pkg: state enum typedef (IDLE, START, DATA, PARITY, STOP), PRESCALE_MIN=8, parity-type constants EVEN=0, ODD=1.
// - Sub-module uart_rx_sampler: edge/bit counters plus 3-sample majority vote; outputs sampled bit, a bit-resolved pulse and a bit-end pulse.
// - Top level holds the FSM, shift register, parity check and output registers.
// TESTING
// - Test 1: PRESCALE=16, PER_EN=1, PAR_TYP=1, frame data 0x55, parity 1, stop 1 -> single DATA_VALID pulse, P_DATA=0x55.
// - Test 2: immediately back-to-back, odd parity, data 0x9F with parity 0 (wrong) -> no DATA_VALID, P_DATA stays 0x55.
// - Test 3: RST pulse, then PAR_TYP=0, data 0x55 parity 0 -> DATA_VALID, P_DATA=0x55.
//   Follow with data 0x9F parity 1 (wrong) -> no strobe.
// - Test 4: PER_EN=0, data 0x5F, stop 1 -> DATA_VALID, P_DATA=0x5F.
//   Follow with data 0x55, stop 0 -> no strobe, P_DATA=0x5F.
// - Test 5: 3-clock low glitch on idle line -> FSM back to IDLE, no strobe.
//   Then a valid frame with PRESCALE=8, data 0xA3, even parity -> P_DATA=0xA3.
// - Test 6: assert RST in the middle of data bit 4 -> DATA_VALID=0, P_DATA=0.
//   The next valid frame is received normally.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the uart_rx receiver: FSM states,
// minimum oversampling rate and parity-type encodings.
package uart_rx_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam logic [5:0] PRESCALE_MIN = 6'd8;
  localparam logic       EVEN         = 1'b0;
  localparam logic       ODD          = 1'b1;

  // Rates below the minimum leave no room for three centred samples.
  function automatic logic [5:0] clamp_prescale(input logic [5:0] p);
    return (p < PRESCALE_MIN) ? PRESCALE_MIN : p;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit timing for uart_rx: edge and bit counters plus a 2-of-3 majority
// vote taken around the middle of each bit.
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int BCW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           run,
  input  logic [5:0]     prescale,
  input  logic           rx,
  output logic           sample_bit,
  output logic           bit_resolved,
  output logic           bit_end,
  output logic [BCW-1:0] bit_cnt
);

  logic [5:0] edge_cnt;
  logic [5:0] mid;
  logic       s_early;
  logic       s_mid;

  assign mid          = {1'b0, prescale[5:1]};
  assign sample_bit   = (s_early & s_mid) | (s_early & rx) | (s_mid & rx);
  assign bit_resolved = run && (edge_cnt == mid + 6'd1);
  assign bit_end      = run && (edge_cnt == prescale - 6'd1);

  // Counters idle at zero whenever the receiver is not inside a frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (!run) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (bit_end) begin
      edge_cnt <= '0;
      bit_cnt  <= bit_cnt + 1'b1;
    end else begin
      edge_cnt <= edge_cnt + 6'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_early <= 1'b1;
      s_mid   <= 1'b1;
    end else begin
      if (edge_cnt == mid - 6'd1) s_early <= rx;
      if (edge_cnt == mid)        s_mid   <= rx;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronizer, framing FSM, shift register and parity check.
// Define UART_RX_ERR_FLAGS_EN to add the PAR_ERR / STP_ERR pulse outputs.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [5:0]   PRESCALE,
  input  logic         PER_EN,
  input  logic         PAR_TYP,
  input  logic         RX_IN,
  output logic         DATA_VALID,
  output logic [W-1:0] P_DATA
`ifdef UART_RX_ERR_FLAGS_EN
  ,
  output logic         PAR_ERR,
  output logic         STP_ERR
`endif
);

  localparam int BCW = $clog2(W + 3);

  state_t         state;
  state_t         next_state;
  logic           rx_meta;
  logic           rx_sync;
  logic           rx_prev;
  logic [5:0]     prescale_q;
  logic           per_en_q;
  logic           par_typ_q;
  logic [W-1:0]   shift_reg;
  logic           par_err;
  logic           sample_bit;
  logic           bit_resolved;
  logic           bit_end;
  logic [BCW-1:0] bit_cnt;
  logic           start_det;
  logic           shift_en;
  logic           par_chk;
  logic           frame_done;
  logic           good_frame;
  logic           expected_par;

  assign start_det  = (state == IDLE) && rx_prev && !rx_sync;
  assign good_frame = frame_done && sample_bit && !par_err;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= RX_IN;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  uart_rx_sampler #(.BCW(BCW)) sampler (
    .clk          (CLK),
    .rst          (RST),
    .run          (state != IDLE),
    .prescale     (prescale_q),
    .rx           (rx_sync),
    .sample_bit   (sample_bit),
    .bit_resolved (bit_resolved),
    .bit_end      (bit_end),
    .bit_cnt      (bit_cnt)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= next_state;
  end

  // The bit counter counts the start bit as bit 0, so data bits are 1..W.
  always_comb begin
    next_state = state;
    shift_en   = 1'b0;
    par_chk    = 1'b0;
    frame_done = 1'b0;
    unique case (state)
      IDLE: if (start_det) next_state = START;
      START: begin
        if (bit_resolved && sample_bit) next_state = IDLE;
        else if (bit_end)               next_state = DATA;
      end
      DATA: begin
        shift_en = bit_resolved;
        if (bit_end && (bit_cnt == BCW'(W))) next_state = per_en_q ? PARITY : STOP;
      end
      PARITY: begin
        par_chk = bit_resolved;
        if (bit_end) next_state = STOP;
      end
      STOP: begin
        if (bit_resolved) begin
          frame_done = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    expected_par = 1'b0;
    unique case (par_typ_q)
      EVEN: expected_par = ^shift_reg;
      ODD:  expected_par = ~^shift_reg;
      default: expected_par = 1'b0;
    endcase
  end

  // Frame settings are captured at the start edge so mid-frame input changes are ignored.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      prescale_q <= PRESCALE_MIN;
      per_en_q   <= 1'b0;
      par_typ_q  <= EVEN;
      shift_reg  <= '0;
      par_err    <= 1'b0;
      DATA_VALID <= 1'b0;
      P_DATA     <= '0;
    end else begin
      if (start_det) begin
        prescale_q <= clamp_prescale(PRESCALE);
        per_en_q   <= PER_EN;
        par_typ_q  <= PAR_TYP;
        par_err    <= 1'b0;
      end
      if (shift_en) shift_reg <= {sample_bit, shift_reg[W-1:1]};
      if (par_chk)  par_err   <= (sample_bit != expected_par);
      DATA_VALID <= good_frame;
      if (good_frame) P_DATA <= shift_reg;
    end
  end

`ifdef UART_RX_ERR_FLAGS_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      PAR_ERR <= 1'b0;
      STP_ERR <= 1'b0;
    end else begin
      PAR_ERR <= frame_done && par_err;
      STP_ERR <= frame_done && !sample_bit;
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are built from a byte-level model,
// expected results queued on issue and checked by an independent monitor.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST;
  logic [5:0]   PRESCALE;
  logic         PER_EN;
  logic         PAR_TYP;
  logic         RX_IN;
  logic         DATA_VALID;
  logic [W-1:0] P_DATA;
`ifdef UART_RX_ERR_FLAGS_EN
  logic         PAR_ERR;
  logic         STP_ERR;
`endif

  typedef struct packed {
    logic         good;
    logic [W-1:0] data;
    logic         perr;
    logic         serr;
  } exp_t;

  exp_t         expq[$];
  exp_t         mon_e;
  int           compared   = 0;
  int           mismatched = 0;
  logic [W-1:0] last_good  = '0;
  logic         obs_event;

  always #5 CLK = ~CLK;

  uart_rx #(.W(W)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .PRESCALE   (PRESCALE),
    .PER_EN     (PER_EN),
    .PAR_TYP    (PAR_TYP),
    .RX_IN      (RX_IN),
    .DATA_VALID (DATA_VALID),
    .P_DATA     (P_DATA)
`ifdef UART_RX_ERR_FLAGS_EN
    ,
    .PAR_ERR    (PAR_ERR),
    .STP_ERR    (STP_ERR)
`endif
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

`ifdef UART_RX_ERR_FLAGS_EN
  assign obs_event = DATA_VALID | PAR_ERR | STP_ERR;
`else
  assign obs_event = DATA_VALID;
`endif

  // Monitor: every output event must match the oldest queued expectation.
  always @(negedge CLK) begin
    if (!RST && obs_event) begin
      if (expq.size() == 0) begin
`ifdef UART_RX_ERR_FLAGS_EN
        checkOutput("unexpected_output", {29'd0, DATA_VALID, PAR_ERR, STP_ERR}, 32'd0);
`else
        checkOutput("unexpected_output", {31'd0, DATA_VALID}, 32'd0);
`endif
      end else begin
        mon_e = expq.pop_front();
        checkOutput("data_valid", {31'd0, DATA_VALID}, {31'd0, mon_e.good});
        if (mon_e.good) checkOutput("p_data", {24'd0, P_DATA}, {24'd0, mon_e.data});
`ifdef UART_RX_ERR_FLAGS_EN
        checkOutput("par_err", {31'd0, PAR_ERR}, {31'd0, mon_e.perr});
        checkOutput("stp_err", {31'd0, STP_ERR}, {31'd0, mon_e.serr});
`endif
      end
    end
  end

  task automatic driveBit(input logic v, input int len);
    RX_IN = v;
    repeat (len) @(posedge CLK);
    #1;
  endtask

  task automatic idleLine(input int cycles);
    driveBit(1'b1, cycles);
  endtask

  // Builds one frame from its fields; the expected outcome follows the framing rules directly.
  task automatic applyStimulus(input logic [W-1:0] data, input logic [5:0] ps, input logic pe,
                               input logic pt, input logic par_ok, input logic stop_bit);
    int   bit_len;
    logic par_bit;
    exp_t e;
    bit_len = (ps < 6'd8) ? 8 : int'(ps);
    par_bit = pt ? ~^data : ^data;
    if (!par_ok) par_bit = ~par_bit;
    e.good = stop_bit && (!pe || par_ok);
    e.data = data;
    e.perr = pe && !par_ok;
    e.serr = !stop_bit;
    if (e.good) begin
      expq.push_back(e);
      last_good = data;
    end
`ifdef UART_RX_ERR_FLAGS_EN
    else expq.push_back(e);
`endif
    PRESCALE = ps;
    PER_EN   = pe;
    PAR_TYP  = pt;
    driveBit(1'b0, bit_len);
    for (int i = 0; i < W; i++) driveBit(data[i], bit_len);
    if (pe) driveBit(par_bit, bit_len);
    driveBit(stop_bit, bit_len);
  endtask

  task automatic drainAndCheck(input string name);
    int waited = 0;
    while (expq.size() != 0 && waited < 300) begin
      @(posedge CLK);
      #1;
      waited++;
    end
    checkOutput({name, "_pending"}, expq.size(), 32'd0);
    expq.delete();
    idleLine(4);
    checkOutput({name, "_p_data_held"}, {24'd0, P_DATA}, {24'd0, last_good});
  endtask

  task automatic pulseReset(input string name);
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    expq.delete();
    last_good = '0;
    checkOutput({name, "_data_valid"}, {31'd0, DATA_VALID}, 32'd0);
    checkOutput({name, "_p_data"}, {24'd0, P_DATA}, {24'd0, last_good});
    RST = 1'b0;
    idleLine(20);
  endtask

  initial begin
    RST      = 1'b1;
    RX_IN    = 1'b1;
    PRESCALE = 6'd16;
    PER_EN   = 1'b0;
    PAR_TYP  = 1'b0;
    @(posedge CLK);
    #1;
    pulseReset("reset");

    $display("[TB] test 1/2: odd parity, good then back-to-back bad");
    applyStimulus(8'h55, 6'd16, 1'b1, 1'b1, 1'b1, 1'b1);
    applyStimulus(8'h9F, 6'd16, 1'b1, 1'b1, 1'b0, 1'b1);
    drainAndCheck("t2");

    $display("[TB] test 3: even parity after reset");
    pulseReset("t3_reset");
    applyStimulus(8'h55, 6'd16, 1'b1, 1'b0, 1'b1, 1'b1);
    drainAndCheck("t3_good");
    applyStimulus(8'h9F, 6'd16, 1'b1, 1'b0, 1'b0, 1'b1);
    drainAndCheck("t3_bad");

    $display("[TB] test 4: no parity, then framing error");
    applyStimulus(8'h5F, 6'd16, 1'b0, 1'b0, 1'b1, 1'b1);
    drainAndCheck("t4_good");
    applyStimulus(8'h55, 6'd16, 1'b0, 1'b0, 1'b1, 1'b0);
    idleLine(16);
    drainAndCheck("t4_stop");

    $display("[TB] test 5: glitch then PRESCALE=8 frame");
    PRESCALE = 6'd8;
    driveBit(1'b0, 3);
    idleLine(40);
    drainAndCheck("t5_glitch");
    applyStimulus(8'hA3, 6'd8, 1'b1, 1'b0, 1'b1, 1'b1);
    drainAndCheck("t5_frame");

    $display("[TB] test 6: reset in data bit 4");
    PRESCALE = 6'd16;
    PER_EN   = 1'b0;
    driveBit(1'b0, 16);
    for (int i = 0; i < 4; i++) driveBit(i[0], 16);
    driveBit(1'b1, 8);
    RX_IN = 1'b1;
    pulseReset("t6_reset");
    applyStimulus(8'hC6, 6'd16, 1'b1, 1'b1, 1'b1, 1'b1);
    drainAndCheck("t6_after");

    $display("[TB] random frames");
    begin
      logic prev_stop;
      prev_stop = 1'b1;
      for (int n = 0; n < 24; n++) begin
        logic [5:0] ps;
        logic       stop_bit;
        ps       = 6'($urandom_range(0, 63));
        stop_bit = ($urandom_range(0, 4) != 0);
        if (!prev_stop || $urandom_range(0, 1) == 1) idleLine($urandom_range(8, 70));
        applyStimulus(8'($urandom), ps, 1'($urandom), 1'($urandom),
                      ($urandom_range(0, 3) != 0), stop_bit);
        prev_stop = stop_bit;
      end
      idleLine(8);
      drainAndCheck("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
